// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and phase word type.
// Phase words are signed Q9.7 degrees.
package cordic_pkg;

  localparam int WORD_LENGTH = 16;
  localparam int FRAC_BITS   = 7;

  typedef logic signed [WORD_LENGTH-1:0] phase_t;

  localparam phase_t PHASE_POS_90 = 16'sh2D00;
  localparam phase_t PHASE_NEG_90 = 16'shD300;

endpackage

// File: rtl/cordic_result_ptr_ctrl.sv
// Result FIFO bookkeeping: pointers, count,
// full/empty and push/pop qualification.
module cordic_result_ptr_ctrl #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic                  m_ready,
  output logic                  push,
  output logic                  pop,
  output logic                  drop,
  output logic                  full,
  output logic                  m_valid,
  output logic                  start_allow,
  output logic [DEPTH_LOG2-1:0] wr_ptr,
  output logic [DEPTH_LOG2-1:0] rd_ptr,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] DEPTH_C =
    (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] DEPTH_M1 =
    DEPTH_C - (DEPTH_LOG2+1)'(1);

  assign full        = (count == DEPTH_C);
  assign m_valid     = (count != '0);
  // keep one slot spare for the conversion in flight
  assign start_allow = (count < DEPTH_M1);
  assign pop         = m_valid & m_ready;
  assign push        = done & (~full | pop);
  assign drop        = done & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(push);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(pop);
      count  <= count + (DEPTH_LOG2+1)'(push)
                      - (DEPTH_LOG2+1)'(pop);
    end
  end

endmodule

// File: rtl/cordic_phase_result_fifo.sv
// CORDIC phase result FIFO with valid/ready output.
// Optional level port: define CORDIC_RESULT_LEVEL_EN.
module cordic_phase_result_fifo
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH = cordic_pkg::WORD_LENGTH,
  parameter int DEPTH_LOG2  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   done,
  input  logic [WORD_LENGTH-1:0] z_in,
  output logic                   start_allow,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WORD_LENGTH-1:0] m_data,
  output logic                   overflow,
  input  logic                   clear_overflow
`ifdef CORDIC_RESULT_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]    level
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] ONE =
    (DEPTH_LOG2+1)'(1);

  logic                   push, pop, drop, full;
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr, rd_nxt;
  logic [DEPTH_LOG2:0]    count;
  logic [WORD_LENGTH-1:0] mem [DEPTH];

  cordic_result_ptr_ctrl #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ptr (
    .clk         (clk),
    .rst         (rst),
    .done        (done),
    .m_ready     (m_ready),
    .push        (push),
    .pop         (pop),
    .drop        (drop),
    .full        (full),
    .m_valid     (m_valid),
    .start_allow (start_allow),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count)
  );

  assign rd_nxt = rd_ptr + DEPTH_LOG2'(1);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= z_in;
  end

  // head register: next entry on pop, bypass z_in when FIFO drains to it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data <= '0;
    end else if (pop) begin
      if (count == ONE) begin
        if (push) m_data <= z_in;
      end else begin
        m_data <= mem[rd_nxt];
      end
    end else if (push && count == '0) begin
      m_data <= z_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

`ifdef CORDIC_RESULT_LEVEL_EN
  assign level = count;
`endif

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_cordic_phase_result_fifo.sv
// Scoreboard bench for cordic_phase_result_fifo.
// Expected words queued on accepted done, compared on pop.
module tb_cordic_phase_result_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done = 1'b0;
  logic [15:0] z_in = '0;
  logic        start_allow;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        overflow;
  logic        clear_overflow = 1'b0;
`ifdef CORDIC_RESULT_LEVEL_EN
  logic [2:0]  level;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] sb[$];
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  cordic_phase_result_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .done           (done),
    .z_in           (z_in),
    .start_allow    (start_allow),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef CORDIC_RESULT_LEVEL_EN
    ,
    .level          (level)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // one clock: drive, check at negedge, update model, return at posedge+1
  task automatic cyc(input logic d, input logic [15:0] z,
                     input logic r, input logic clr);
    bit p_pop, p_push;
    done = d; z_in = z; m_ready = r; clear_overflow = clr;
    @(negedge clk);
    chk("m_valid", m_valid, sb.size() != 0);
    chk("start_allow", start_allow, sb.size() < DEPTH-1);
    chk("overflow", overflow, m_ovf);
`ifdef CORDIC_RESULT_LEVEL_EN
    chk("level", level, sb.size());
`endif
    if (sb.size() != 0) chk("m_data", m_data, sb[0]);
    p_pop  = (sb.size() != 0) && r;
    p_push = d && ((sb.size() < DEPTH) || p_pop);
    if (p_pop) void'(sb.pop_front());
    if (p_push) sb.push_back(z);
    if (d && !p_push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk); #1;
    done = 1'b0; m_ready = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 16'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_allow", start_allow, 1'b1);
    sb.delete();
    m_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rel_valid", m_valid, 1'b0);
    chk("rel_allow", start_allow, 1'b1);
  endtask

  logic [15:0] t3 [4] = '{16'h0080, 16'hFF80, 16'h1680, 16'hD300};

  initial begin
    #1;
    do_reset();

    // single word, held while not ready
    cyc(1, 16'h2D00, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // fill to full, then drain
    for (int i = 0; i < 4; i++) cyc(1, t3[i], 0, 0);
    cyc(0, 0, 0, 0);
    chk("full_n", sb.size(), 4);

    // drop when full, then clear overflow
    cyc(1, 16'h1234, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // push+pop while full: word goes last
    cyc(1, 16'h4321, 1, 0);
    cyc(0, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 0);

    // count==1 push+pop keeps m_valid
    cyc(1, 16'h0A0A, 0, 0);
    cyc(1, 16'hB0B0, 1, 0);
    cyc(1, 16'hC0C0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // drop and clear in same cycle: set wins
    repeat (4) cyc(1, 16'h1111, 0, 0);
    cyc(1, 16'h2222, 0, 1);
    cyc(0, 0, 0, 0);

    // reset mid-stream
    do_reset();
    cyc(0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 1), 16'($urandom),
          $urandom_range(0, 1), $urandom_range(0, 7) == 0);
    repeat (6) cyc(0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
